// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each {anode,segment} value,
// decodes it back to BCD and publishes complete 4-digit frames plus error pulses.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode_in,
    input  logic [7:0]  seg_in,
    output logic [15:0] digits_out,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        anode_err,
    output logic [7:0]  err_count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [11:0]   in_q;
    logic [CW-1:0] cnt;
    logic [3:0]    mask;
    logic [3:0]    dp_buf;
    logic [3:0]    frame_buf [4];

    logic [11:0] in_now;
    logic        same;
    logic        accept;
    logic        slot_ok;
    logic        anode_bad;
    logic [1:0]  slot_idx;
    logic        seg_bad;
    logic [3:0]  digit;
    logic [3:0]  wr_mask;
    logic [15:0] next_digits;
    logic [3:0]  next_dp;
    logic        write;
    logic        frame_done;
    logic        err_event;

    assign in_now = {anode_in, seg_in};
    assign same   = (in_now == in_q);
    // cnt holds (edges seen - 1), so reaching STABLE_CYCLES-1 on this edge means cnt is S-2 now.
    assign accept = same && (cnt == CNT_ACC);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        slot_ok     = 1'b0;
        anode_bad   = 1'b0;
        slot_idx    = 2'd0;
        seg_bad     = 1'b0;
        digit       = 4'hE;
        next_digits = '0;
        next_dp     = '0;

        case (in_q[11:8])
            4'b1110: begin slot_ok = 1'b1; slot_idx = 2'd0; end
            4'b1101: begin slot_ok = 1'b1; slot_idx = 2'd1; end
            4'b1011: begin slot_ok = 1'b1; slot_idx = 2'd2; end
            4'b0111: begin slot_ok = 1'b1; slot_idx = 2'd3; end
            4'b1111: ;
            default: anode_bad = 1'b1;
        endcase

        case (in_q[6:0])
            7'h40:   digit = 4'd0;
            7'h79:   digit = 4'd1;
            7'h24:   digit = 4'd2;
            7'h30:   digit = 4'd3;
            7'h19:   digit = 4'd4;
            7'h12:   digit = 4'd5;
            7'h02:   digit = 4'd6;
            7'h78:   digit = 4'd7;
            7'h00:   digit = 4'd8;
            7'h10:   digit = 4'd9;
            7'h7F:   digit = 4'hF;
            default: seg_bad = 1'b1;
        endcase

        wr_mask = mask | (4'b0001 << slot_idx);

        // Frame view including the slot being written this edge.
        for (int i = 0; i < 4; i++) begin
            next_digits[i*4 +: 4] = (slot_idx == 2'(i)) ? digit : frame_buf[i];
            next_dp[i]            = (slot_idx == 2'(i)) ? ~in_q[7] : dp_buf[i];
        end
    end

    assign write      = accept && slot_ok;
    assign frame_done = write && (wr_mask == 4'hF);
    assign err_event  = accept && (anode_bad || (slot_ok && seg_bad));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            in_q        <= 12'hFFF;
            cnt         <= '0;
            mask        <= '0;
            dp_buf      <= '0;
            // NOTE: the frame buffer is tiny and its reset value (blank) is observable, so it is reset.
            for (int i = 0; i < 4; i++) frame_buf[i] <= 4'hF;
            digits_out  <= 16'hFFFF;
            dp_out      <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            anode_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            in_q <= in_now;
            if (!same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_ONE;

            frame_valid <= frame_done;
            seg_err     <= write && seg_bad;
            anode_err   <= accept && anode_bad;

            if (write) begin
                frame_buf[slot_idx] <= digit;
                dp_buf[slot_idx]    <= ~in_q[7];
                mask                <= frame_done ? 4'b0000 : wr_mask;
            end
            if (frame_done) begin
                digits_out <= next_digits;
                dp_out     <= next_dp;
            end

            if (err_event && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: hand-computed vector table, directed corner
// sequences and randomized traffic compared every cycle against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  anode_in;
    logic [7:0]  seg_in;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        seg_err;
    logic        anode_err;
    logic [7:0]  err_count;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .anode_in    (anode_in),
        .seg_in      (seg_in),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .anode_err   (anode_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a value is accepted when it has been seen on exactly S consecutive edges.
    logic [11:0] m_prev;
    int          m_run;
    logic [3:0]  m_slot [4];
    logic        m_dpb  [4];
    logic [3:0]  m_have;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic        m_fv, m_se, m_ae;
    int          m_ec;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int seg_value(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
        if (p == 7'h7F) return 15;
        return 14;
    endfunction

    task automatic model_reset();
        m_prev = 12'hFFF; m_run = 1; m_have = 4'h0;
        m_digits = 16'hFFFF; m_dp = 4'h0; m_ec = 0;
        m_fv = 1'b0; m_se = 1'b0; m_ae = 1'b0;
        for (int i = 0; i < 4; i++) begin m_slot[i] = 4'hF; m_dpb[i] = 1'b0; end
    endtask

    task automatic model_accept(input logic [11:0] v);
        int idx;
        int d;
        idx = 0;
        if (v[11:8] == 4'hF) return;
        if ($countones(v[11:8]) != 3) begin
            m_ae = 1'b1;
            if (m_ec < 255) m_ec++;
            return;
        end
        for (int i = 0; i < 4; i++) if (!v[8+i]) idx = i;
        d = seg_value(v[6:0]);
        if (d == 14) begin
            m_se = 1'b1;
            if (m_ec < 255) m_ec++;
        end
        m_slot[idx] = 4'(d);
        m_dpb[idx]  = ~v[7];
        m_have[idx] = 1'b1;
        if (m_have == 4'hF) begin
            m_digits = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_dp     = {m_dpb[3], m_dpb[2], m_dpb[1], m_dpb[0]};
            m_fv     = 1'b1;
            m_have   = 4'h0;
        end
    endtask

    task automatic model_edge(input logic [11:0] v, input logic r);
        m_fv = 1'b0; m_se = 1'b0; m_ae = 1'b0;
        if (r) begin
            model_reset();
            return;
        end
        if (v == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = v;
        if (m_run == S) model_accept(v);
    endtask

    int n_fv, n_se, n_ae;

    // One clock: apply inputs, let the edge happen, then compare everything against the model.
    task automatic drive(input logic [3:0] a, input logic [7:0] s);
        anode_in = a;
        seg_in   = s;
        @(posedge clk);
        #1;
        model_edge({a, s}, rst);
        check("digits_out",  32'(digits_out),  32'(m_digits));
        check("dp_out",      32'(dp_out),      32'(m_dp));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("seg_err",     32'(seg_err),     32'(m_se));
        check("anode_err",   32'(anode_err),   32'(m_ae));
        check("err_count",   32'(err_count),   32'(m_ec));
        n_fv += int'(frame_valid);
        n_se += int'(seg_err);
        n_ae += int'(anode_err);
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        for (int k = 0; k < n; k++) drive(a, s);
    endtask

    task automatic clear_counts();
        n_fv = 0; n_se = 0; n_ae = 0;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  sg;
        int          hold;
        logic [15:0] dig;
        logic [3:0]  dp;
        int          ec;
        int          fv;
        int          se;
        int          ae;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [3:0] ra;
        logic [7:0] rs;
        int kind;
        int hl;

        tbl[0]  = '{4'b1110, 8'hC0, 6, 16'hFFFF, 4'b0000, 0, 0, 0, 0};
        tbl[1]  = '{4'b1101, 8'hF9, 6, 16'hFFFF, 4'b0000, 0, 0, 0, 0};
        tbl[2]  = '{4'b1011, 8'hA4, 6, 16'hFFFF, 4'b0000, 0, 0, 0, 0};
        tbl[3]  = '{4'b0111, 8'hB0, 6, 16'h3210, 4'b0000, 0, 1, 0, 0};
        tbl[4]  = '{4'b1110, 8'hFE, 6, 16'h3210, 4'b0000, 1, 0, 1, 0};
        tbl[5]  = '{4'b1101, 8'hF9, 6, 16'h3210, 4'b0000, 1, 0, 0, 0};
        tbl[6]  = '{4'b1011, 8'hA4, 6, 16'h3210, 4'b0000, 1, 0, 0, 0};
        tbl[7]  = '{4'b0111, 8'hB0, 6, 16'h321E, 4'b0000, 1, 1, 0, 0};
        tbl[8]  = '{4'b1110, 8'hC0, 6, 16'h321E, 4'b0000, 1, 0, 0, 0};
        tbl[9]  = '{4'b1101, 8'hF9, 6, 16'h321E, 4'b0000, 1, 0, 0, 0};
        tbl[10] = '{4'b1011, 8'h40, 6, 16'h321E, 4'b0000, 1, 0, 0, 0};
        tbl[11] = '{4'b0111, 8'hFF, 6, 16'hF010, 4'b0100, 1, 1, 0, 0};
        tbl[12] = '{4'b1100, 8'hC0, 6, 16'hF010, 4'b0100, 2, 0, 0, 1};
        tbl[13] = '{4'b1111, 8'h55, 6, 16'hF010, 4'b0100, 2, 0, 0, 0};
        tbl[14] = '{4'b1110, 8'h99, 6, 16'hF010, 4'b0100, 2, 0, 0, 0};
        tbl[15] = '{4'b1101, 8'h92, 6, 16'hF010, 4'b0100, 2, 0, 0, 0};
        tbl[16] = '{4'b1011, 8'h82, 6, 16'hF010, 4'b0100, 2, 0, 0, 0};
        tbl[17] = '{4'b0111, 8'hF8, 6, 16'h7654, 4'b0000, 2, 1, 0, 0};

        model_reset();
        clear_counts();
        rst = 1'b1;
        hold(4'hF, 8'hFF, 2);
        check("reset digits_out",  32'(digits_out),  32'hFFFF);
        check("reset dp_out",      32'(dp_out),      32'h0);
        check("reset frame_valid", 32'(frame_valid), 32'h0);
        check("reset err_count",   32'(err_count),   32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            clear_counts();
            hold(tbl[i].an, tbl[i].sg, tbl[i].hold);
            check($sformatf("vec%0d digits", i), 32'(digits_out), 32'(tbl[i].dig));
            check($sformatf("vec%0d dp", i),     32'(dp_out),     32'(tbl[i].dp));
            check($sformatf("vec%0d ec", i),     32'(err_count),  32'(tbl[i].ec));
            check($sformatf("vec%0d fv#", i),    32'(n_fv),       32'(tbl[i].fv));
            check($sformatf("vec%0d se#", i),    32'(n_se),       32'(tbl[i].se));
            check($sformatf("vec%0d ae#", i),    32'(n_ae),       32'(tbl[i].ae));
        end

        // Short glitch must not write a slot; a long hold accepts exactly once.
        clear_counts();
        hold(4'b1110, 8'hF9, S - 1);
        hold(4'b1101, 8'hF9, 6);
        hold(4'b1011, 8'hA4, 6);
        hold(4'b0111, 8'hB0, 6);
        check("glitch no frame", 32'(n_fv), 32'd0);
        clear_counts();
        hold(4'b1110, 8'hF9, 50);
        check("long hold frame#", 32'(n_fv),       32'd1);
        check("long hold digits", 32'(digits_out), 32'h3211);
        clear_counts();
        hold(4'b1101, 8'hF9, 6);
        hold(4'b1011, 8'hA4, 6);
        hold(4'b0111, 8'hB0, 6);
        check("no re-accept", 32'(n_fv), 32'd0);

        // Reset mid-frame discards the partial capture.
        rst = 1'b1;
        hold(4'hF, 8'hFF, 1);
        rst = 1'b0;
        clear_counts();
        hold(4'b1110, 8'hC0, 6);
        hold(4'b1101, 8'hF9, 6);
        rst = 1'b1;
        hold(4'b1101, 8'hF9, 1);
        rst = 1'b0;
        hold(4'b1011, 8'hA4, 6);
        hold(4'b0111, 8'hB0, 6);
        check("midreset no frame",  32'(n_fv),       32'd0);
        check("midreset digits",    32'(digits_out), 32'hFFFF);

        // Drive the error counter to saturation.
        for (int i = 0; i < 255; i++)
            hold((i % 2 == 0) ? 4'b1100 : 4'b1010, 8'hC0, S);
        check("ec at 255", 32'(err_count), 32'd255);
        clear_counts();
        hold(4'b0011, 8'hC0, S + 1);
        check("sat anode pulse", 32'(n_ae),      32'd1);
        check("sat ec hold",     32'(err_count), 32'd255);
        clear_counts();
        hold(4'b1110, 8'hFE, S + 1);
        check("sat seg pulse", 32'(n_se),      32'd1);
        check("sat ec hold2",  32'(err_count), 32'd255);

        // Randomized traffic against the model, with occasional resets.
        for (int it = 0; it < 400; it++) begin
            kind = int'($urandom_range(0, 11));
            hl   = int'($urandom_range(1, 7));
            ra   = 4'b1111 ^ (4'b0001 << $urandom_range(0, 3));
            rs   = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 9)]};
            if (kind == 0) begin
                ra = 4'b1111;
            end else if (kind == 1) begin
                ra = 4'($urandom);
                while ($countones(ra) == 3 || ra == 4'b1111) ra = 4'($urandom);
            end else if (kind == 2) begin
                rs = 8'($urandom);
            end else if (kind == 3) begin
                rs = {1'($urandom_range(0, 1)), 7'h7F};
            end
            rst = ($urandom_range(0, 99) < 2);
            hold(ra, rs, 1);
            rst = 1'b0;
            hold(ra, rs, hl - 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the team's 7-segment display drivers. It snoops a multiplexed active-low anode/segment bus, debounces each anode/segment combination and decodes the segment patterns back to BCD digits. It reconstructs a complete 4-digit frame and flags illegal segment or anode patterns. It serves as an on-chip display monitor and as a self-check block for counter/display labs.

Parameters:
STABLE_CYCLES, 4, number of consecutive clock edges an {anode,segment} value must be held before it is accepted; legal range 2..15.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
anode_in  input  4  display anodes, active-low; bit0 = digit0
seg_in  input  8  segments, active-low; bit7 = dp, bits6:0 = g..a
digits_out  output  16  last complete frame, 4 nibbles; [3:0] = digit0; 4'hF = blank, 4'hE = undecodable
dp_out  output  4  decimal points of last complete frame, active-high
frame_valid  output  1  one-cycle pulse when digits_out/dp_out update
seg_err  output  1  one-cycle pulse: accepted segment pattern not 0-9 and not blank
anode_err  output  1  one-cycle pulse: accepted anode value not one-hot-low and not all-ones
err_count  output  8  saturating count of seg_err + anode_err events

Behaviour:
- Input stage: in_q <= {anode_in, seg_in} every edge. Stability counter cnt:
  - cleared when the new input differs from in_q;
  - otherwise increments, saturating at STABLE_CYCLES.
- Accept event: fires once, on the edge where cnt reaches STABLE_CYCLES-1 (the value has been sampled on STABLE_CYCLES consecutive edges).
  - A value first sampled at edge E0 and held is accepted at edge E0+STABLE_CYCLES-1.
  - Effects (slot write, error pulses) are visible after that edge.
  - No re-accept while the value stays constant.
- On accept, decode anode:
  - 4'b1111: display blanked; ignored, no error.
  - Exactly one bit low: slot index = position of the low bit.
  - Anything else: anode_err=1 for one cycle, err_count+1, no slot write.
- Segment decode (bits6:0, active-low; bit7 is don't-care for the digit):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, 7-bit).
  - 7'h7F gives 4'hF (blank), no error.
  - Any other pattern gives 4'hE, seg_err=1 for one cycle, err_count+1.
  - dp = ~seg[7].
- Slot write: frame_buf[slot] <= decoded value, dp_buf[slot] <= dp, mask[slot] <= 1.
  - Re-accepting an already captured slot overwrites it; mask unchanged.
- Frame completion: on the edge where the write makes mask == 4'b1111:
  - digits_out/dp_out load frame_buf/dp_buf including the value being written;
  - frame_valid=1 for that cycle;
  - mask <= 0.
  - Frame slots may arrive in any order.
- seg_err and anode_err are mutually exclusive; when both events coincide with err_count = 255, err_count holds at 255.
- Reset values: digits_out=16'hFFFF, dp_out=0, frame_valid=0, seg_err=0, anode_err=0, err_count=0, mask=0, frame_buf=all F, cnt=0, in_q={4'b1111,8'hFF}.
- Reset mid-frame discards partial capture. The first accept after reset release needs a full STABLE_CYCLES hold.

Test Plan:
1. Reset; hold each of (1110,C0), (1101,F9), (1011,A4), (0111,B0) for 6 cycles -> one frame_valid pulse, at accept of the 4th value; digits_out=16'h3210, dp_out=0, err_count=0.
2. (1110,F9) held STABLE_CYCLES-1 cycles, then changed -> no slot write, no pulses; held STABLE_CYCLES cycles -> accepted exactly once even if held 50 cycles.
3. (1110,FE) held 6 cycles -> seg_err single pulse, err_count=1; complete the frame with valid digits -> digits_out[3:0]=4'hE.
4. (1100,C0) held 6 cycles -> anode_err pulse, err_count=1, mask unchanged; (1111,xx) -> no effect.
5. Frame with digit2 pattern 8'h40 -> dp_out=4'b0100, digits_out[11:8]=0; blank 8'hFF on digit3 -> nibble F, no error.
6. Capture 2 digits, assert rst one cycle, then send 2 more digits -> no frame_valid; err_count forced to 255 then one more error -> stays 255.
